bus_master: RTL

- Initiator side of the uniboard internal peripheral bus. Converts a single-entry command stream from the command parser into select/rw/register_addr/databus transactions to one of up to 8 peripherals.
- Captures the read data and reg_size reply from the addressed peripheral and returns them as one response.
- One transaction is in flight at a time.

---
 rtl/bus_master.sv | 127 ++++++++++++
 1 files changed

// File: rtl/bus_master.sv
// bus_master: initiator on the uniboard internal peripheral bus.
// Takes one command at a time from the command parser, runs a
// select/rw/register_addr/databus transaction against one of 8 peripherals,
// and returns the captured read data and reg_size reply as a single response.
//
// Ports:
//   clk_12MHz, reset            clock, synchronous active-high reset
//   cmd_valid/cmd_ready         command handshake
//   cmd_periph/addr/rw/wdata    command fields (rw: 0 = write, 1 = read)
//   databus                     shared bidirectional data bus
//   reg_size                    reply size from the selected peripheral
//   register_addr, rw, select   bus address, direction, one-hot selects
//   rsp_valid/rsp_ready         response handshake
//   rsp_data/size/error         captured read data, size, unknown-register flag
module bus_master #(
  parameter int unsigned HOLD_CYCLES = 4,
  parameter int unsigned GAP_CYCLES  = 2
) (
  input  logic        clk_12MHz,
  input  logic        reset,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [2:0]  cmd_periph,
  input  logic [7:0]  cmd_addr,
  input  logic        cmd_rw,
  input  logic [31:0] cmd_wdata,
  inout  wire  [31:0] databus,
  input  logic [2:0]  reg_size,
  output logic [7:0]  register_addr,
  output logic        rw,
  output logic [7:0]  select,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_data,
  output logic [2:0]  rsp_size,
  output logic        rsp_error
);

  typedef enum logic [2:0] {
    IDLE,
    SETUP,
    STROBE,
    RESP,
    GAP
  } state_t;

  state_t      state;
  logic [2:0]  periph_q;
  logic [31:0] wdata_q;
  logic        drive_en;
  logic [7:0]  cnt;

  assign cmd_ready = (state == IDLE) && !reset;

  // drive_en is set at command capture for writes and cleared when leaving
  // STROBE, so the bus is driven exactly in SETUP and STROBE of a write.
  assign databus = drive_en ? wdata_q : 'z;

  always_ff @(posedge clk_12MHz) begin
    if (reset) begin
      state         <= IDLE;
      select        <= '0;
      rw            <= 1'b1;
      register_addr <= '0;
      drive_en      <= 1'b0;
      rsp_valid     <= 1'b0;
      rsp_data      <= '0;
      rsp_size      <= '0;
      rsp_error     <= 1'b0;
      cnt           <= '0;
      periph_q      <= '0;
      wdata_q       <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (cmd_valid) begin
            // Address and direction are presented from SETUP onwards.
            periph_q      <= cmd_periph;
            register_addr <= cmd_addr;
            rw            <= cmd_rw;
            wdata_q       <= cmd_wdata;
            drive_en      <= !cmd_rw;
            state         <= SETUP;
          end
        end
        SETUP: begin
          select <= 8'b1 << periph_q;
          cnt    <= 8'(HOLD_CYCLES - 1);
          state  <= STROBE;
        end
        STROBE: begin
          if (cnt == '0) begin
            select    <= '0;
            drive_en  <= 1'b0;
            rsp_size  <= reg_size;
            rsp_data  <= rw ? databus : '0;
            rsp_error <= (reg_size == 3'd0);
            rsp_valid <= 1'b1;
            state     <= RESP;
          end else begin
            cnt <= cnt - 8'd1;
          end
        end
        RESP: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            cnt       <= 8'(GAP_CYCLES - 1);
            state     <= GAP;
          end
        end
        GAP: begin
          if (cnt == '0) begin
            state <= IDLE;
          end else begin
            cnt <= cnt - 8'd1;
          end
        end
        default: begin
          select   <= '0;
          drive_en <= 1'b0;
          state    <= IDLE;
        end
      endcase
    end
  end

endmodule
